booth_mult_seq: RTL and testbench
=================================

Name: booth_mult_seq

Overview:
Parametrised sequential radix-2 Booth multiplier with a go/done level handshake. It is the general successor to the fixed 8-bit signed multiplier, adding operand width W, signed/unsigned mode, a busy flag, abort-on-go-drop and an asynchronous reset. It sits in the datapath as a multi-cycle arithmetic unit driven by a controller that holds go until it has consumed done.

Parameters:
W, 8, operand width in bits (W >= 2); product width is 2W
CW, $clog2(W+1), iteration counter width (derived, not overridden)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
go  input  1  level request; high in IDLE starts an operation; low aborts or releases the result
mode_signed  input  1  1 = two's-complement operands, 0 = unsigned; sampled at load
ain  input  W  multiplicand; sampled at load
pin  input  W  multiplier; sampled at load
busy  output  1  high while iterating (RUN)
done  output  1  high in DONE; p valid
p  output  2W  product; holds last completed result

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, busy=0, done=0, p=0, internal accumulator/counter cleared. Deassertion takes effect at the next clk edge.
- States: IDLE, RUN, DONE.
- IDLE: on an edge with go=1, go to RUN. Extend ain and pin to W+1 bits: sign-extend if mode_signed=1, zero-extend if 0. Load M=ext(ain), Q=ext(pin), A=0, q_1=0, count=W.
- RUN: each edge performs one Booth step on {A,Q,q_1}:
  - (Q[0],q_1)=10 gives A-=M.
  - 01 gives A+=M.
  - 00 and 11 leave A unchanged.
  - Then arithmetic-shift {A,Q,q_1} right by 1. A and M are W+1 bits and A is evaluated at W+2 bits internally to avoid overflow.
- RUN with count==0: that step is the last of W+1 steps. On the same edge, p <= low 2W bits of {A,Q} after the shift, and the state goes to DONE.
- Latency: go sampled at edge k; done=1 and p valid after edge k+W+1. For W=8 this is 9 cycles after load.
- DONE: done=1, busy=0. The state stays DONE while go=1. On the first edge with go=0 it returns to IDLE, done falls, and p holds its value.
- Abort: go=0 on any RUN edge returns to IDLE on that edge. p is not updated and done is never asserted.
- go held high continuously never restarts from DONE. A new operation needs go low for at least one edge.
- Operand/mode changes while in RUN or DONE are ignored.
- busy=1 exactly in RUN; done=1 exactly in DONE. busy and done are never both high.
- Result is exact for all operand pairs in both modes, including -2^(W-1) × -2^(W-1) in signed mode.

Decomposition:
- Package mult_pkg holds:
  - the state typedef (IDLE, RUN, DONE);
  - a function computing the counter width.
- Sub-module booth_step: purely combinational, parametrised by W. Takes {A,Q,q_1} and M, returns the next {A,Q,q_1}.
- booth_mult_seq holds the FSM, counter, registers and handshake.

Test Plan:
- W=8, signed: ain=20, pin=-10, go high → after 9 cycles done=1, p=16'hFF38 (-200). Hold go 1 µs: p stable, no restart. Then go=0 → done=0.
- W=8, signed sequence: (-10,-60) → 16'h0258, then (25,40) → 16'h03E8. Each needs a go low/high cycle; busy high exactly 9 cycles per operation.
- W=8 corners:
  - signed -128 × -128 → 16'h4000;
  - signed -128 × 127 → 16'hC080;
  - unsigned 255 × 255 → 16'hFE01;
  - unsigned 0 × 200 → 16'h0000.
- Abort: start (20,-10) after a prior result 16'h03E8. Drop go on RUN cycle 4 → IDLE next edge, done never high, p stays 16'h03E8. Restart completes correctly.
- Reset mid-RUN: assert rst_n low asynchronously (between edges) → busy, done and p go to 0 immediately. After release, a fresh (25,40) gives 16'h03E8.
- W=16 instance:
  - signed -32768 × -32768 → 32'h40000000 after 17 cycles;
  - unsigned 65535 × 2 → 32'h0001FFFE.
  - Also run 1000 random signed and unsigned pairs checked against a reference model.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared types and helpers for the sequential Booth multiplier.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mult_pkg;

    // Controller states: waiting for go, iterating Booth steps, holding the result.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mult_state_t;

    // Width of the iteration counter: it must hold the value w (loaded at start).
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth iteration on the {A,Q,q_1} register: add/sub M, then arithmetic shift right.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to register the result.
//
// Ports:
//   acc_in  : {A[W:0], Q[W:0], q_1} before the step
//   m       : multiplicand, already extended to W+1 bits
//   acc_out : {A, Q, q_1} after add/sub and shift
module booth_step
    import mult_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [2*W+2:0] acc_in,
    input  logic [W:0]     m,
    output logic [2*W+2:0] acc_out
);

    logic [W:0]   a;
    logic [W:0]   q;
    logic         q_1;
    logic [W+1:0] a_wide;
    logic [W+1:0] m_wide;
    logic [W+1:0] sum;

    assign a   = acc_in[2*W+2:W+2];
    assign q   = acc_in[W+1:1];
    assign q_1 = acc_in[0];

    // A and M are sign-extended one extra bit so the add/sub can never overflow,
    // including when M is the most negative W+1 bit value.
    assign a_wide = {a[W], a};
    assign m_wide = {m[W], m};

    always_comb begin
        sum = a_wide;
        case ({q[0], q_1})
            2'b10:   sum = a_wide - m_wide;
            2'b01:   sum = a_wide + m_wide;
            default: sum = a_wide;
        endcase
    end

    // Arithmetic shift right of {sum, Q, q_1}: the W+2 bit sum already carries the
    // replicated sign, so the shifted register is just {sum, Q} with q_1 dropped.
    // New A = sum[W+1:1], new Q = {sum[0], Q[W:1]}, new q_1 = Q[0].
    assign acc_out = {sum, q};

endmodule

// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier (signed or unsigned W x W -> 2W) with a go/done level handshake.
// Latency: go sampled at edge k, done and p valid after edge k+W+1 (W+1 Booth steps).
// Backpressure: result held in DONE while go stays high; go low in RUN aborts, go low in DONE releases.
//
// Ports:
//   clk, rst_n        : rising-edge clock, asynchronous active-low reset
//   go                : level request; starts from IDLE, must drop before the next operation
//   mode_signed       : 1 = two's-complement operands, 0 = unsigned (sampled at load)
//   ain, pin          : multiplicand and multiplier (sampled at load)
//   busy              : high exactly while iterating
//   done              : high exactly while the result is being offered
//   p                 : product; keeps the last completed result
module booth_mult_seq
    import mult_pkg::*;
#(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           go,
    input  logic           mode_signed,
    input  logic [W-1:0]   ain,
    input  logic [W-1:0]   pin,
    output logic           busy,
    output logic           done,
    output logic [2*W-1:0] p
);

    localparam int CW = cnt_width(W);

    mult_state_t     state;
    mult_state_t     state_nxt;
    logic            load;
    logic            step;
    logic            last;

    logic [W:0]      m;
    logic [2*W+2:0]  acc;
    logic [2*W+2:0]  acc_nxt;
    logic [CW-1:0]   count;
    logic [W:0]      ain_ext;
    logic [W:0]      pin_ext;

    // Extending to W+1 bits lets one signed Booth datapath serve both modes:
    // an unsigned operand becomes a non-negative W+1 bit signed value.
    assign ain_ext = mode_signed ? {ain[W-1], ain} : {1'b0, ain};
    assign pin_ext = mode_signed ? {pin[W-1], pin} : {1'b0, pin};

    booth_step #(.W(W)) u_step (
        .acc_in  (acc),
        .m       (m),
        .acc_out (acc_nxt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        last      = 1'b0;
        case (state)
            IDLE: begin
                if (go) begin
                    state_nxt = RUN;
                    load      = 1'b1;
                end
            end
            RUN: begin
                // Abort wins over completion, even on the final step.
                if (!go) begin
                    state_nxt = IDLE;
                end else begin
                    step = 1'b1;
                    if (count == '0) begin
                        state_nxt = DONE;
                        last      = 1'b1;
                    end
                end
            end
            DONE: begin
                if (!go) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m     <= '0;
            acc   <= '0;
            count <= '0;
            p     <= '0;
        end else begin
            if (load) begin
                m     <= ain_ext;
                acc   <= {{(W+1){1'b0}}, pin_ext, 1'b0};
                count <= CW'(W);
            end else if (step) begin
                acc   <= acc_nxt;
                count <= count - 1'b1;
            end
            // Low 2W bits of {A,Q} after the final shift; exact for both modes
            // because the true product always fits in 2W bits.
            if (last) begin
                p <= acc_nxt[2*W:1];
            end
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule

// File: tb/tb_booth_mult_seq.sv
module tb_booth_mult_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        go8, ms8;
    logic [7:0]  ain8, pin8;
    logic        busy8, done8;
    logic [15:0] p8;
    logic        go16, ms16;
    logic [15:0] ain16, pin16;
    logic        busy16, done16;
    logic [31:0] p16;

    booth_mult_seq #(.W(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .go(go8), .mode_signed(ms8),
        .ain(ain8), .pin(pin8), .busy(busy8), .done(done8), .p(p8)
    );

    booth_mult_seq #(.W(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .go(go16), .mode_signed(ms16),
        .ain(ain16), .pin(pin16), .busy(busy16), .done(done16), .p(p16)
    );

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic        sgn;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] exp;
    } vec_t;

    vec_t tbl[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Starts an operation on the chosen instance and waits (bounded) for done.
    // lat = edges after the load edge until done; bcnt = post-edge samples with busy high.
    task automatic run_op(input bit wide, input bit sgn, input logic [15:0] a, input logic [15:0] b,
                          output logic [31:0] res, output int lat, output int bcnt, output logic both);
        @(negedge clk);
        if (wide) begin
            ms16 = sgn; ain16 = a; pin16 = b; go16 = 1'b1;
        end else begin
            ms8 = sgn; ain8 = a[7:0]; pin8 = b[7:0]; go8 = 1'b1;
        end
        lat  = -1;
        bcnt = 0;
        both = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (wide ? busy16 : busy8) bcnt++;
            if (wide ? (busy16 && done16) : (busy8 && done8)) both = 1'b1;
            if (wide ? done16 : done8) break;
        end
        res = wide ? p16 : {16'h0, p8};
    endtask

    task automatic release_go(input bit wide);
        @(negedge clk);
        if (wide) go16 = 1'b0;
        else      go8  = 1'b0;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] ref16(input bit sgn, input logic [15:0] a, input logic [15:0] b);
        logic [31:0] xa, xb, r;
        xa = sgn ? {{16{a[15]}}, a} : {16'h0, a};
        xb = sgn ? {{16{b[15]}}, b} : {16'h0, b};
        r  = xa * xb;
        return r;
    endfunction

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] res;
        int          lat, bcnt;
        logic        both, saw_done, changed;
        logic [15:0] held;

        tbl[0]  = '{1'b1, 8'd20,  8'hF6, 16'hFF38};  // 20 * -10
        tbl[1]  = '{1'b1, 8'hF6,  8'hC4, 16'h0258};  // -10 * -60
        tbl[2]  = '{1'b1, 8'd25,  8'd40, 16'h03E8};  // 25 * 40
        tbl[3]  = '{1'b1, 8'h80,  8'h80, 16'h4000};  // -128 * -128
        tbl[4]  = '{1'b1, 8'h80,  8'h7F, 16'hC080};  // -128 * 127
        tbl[5]  = '{1'b0, 8'hFF,  8'hFF, 16'hFE01};  // 255 * 255
        tbl[6]  = '{1'b0, 8'h00,  8'hC8, 16'h0000};  // 0 * 200
        tbl[7]  = '{1'b0, 8'hC8,  8'h03, 16'h0258};  // 200 * 3
        tbl[8]  = '{1'b1, 8'hC8,  8'h03, 16'hFF58};  // -56 * 3
        tbl[9]  = '{1'b1, 8'hFF,  8'hFF, 16'h0001};  // -1 * -1
        tbl[10] = '{1'b1, 8'h7F,  8'h7F, 16'h3F01};  // 127 * 127
        tbl[11] = '{1'b1, 8'hFF,  8'h01, 16'hFFFF};  // -1 * 1
        tbl[12] = '{1'b0, 8'h80,  8'h80, 16'h4000};  // 128 * 128

        rst_n = 1'b0;
        go8 = 1'b0; ms8 = 1'b0; ain8 = '0; pin8 = '0;
        go16 = 1'b0; ms16 = 1'b0; ain16 = '0; pin16 = '0;
        #12;
        check("reset busy8", {31'h0, busy8}, 32'h0);
        check("reset done8", {31'h0, done8}, 32'h0);
        check("reset p8", {16'h0, p8}, 32'h0);
        check("reset p16", p16, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven W=8 vectors, each with a full go high/low cycle.
        for (int i = 0; i < 13; i++) begin
            run_op(1'b0, tbl[i].sgn, {8'h0, tbl[i].a}, {8'h0, tbl[i].b}, res, lat, bcnt, both);
            check($sformatf("vec%0d p", i), res, {16'h0, tbl[i].exp});
            check($sformatf("vec%0d latency", i), lat, 9);
            check($sformatf("vec%0d busy cycles", i), bcnt, 9);
            check($sformatf("vec%0d busy&done", i), {31'h0, both}, 32'h0);
            release_go(1'b0);
            check($sformatf("vec%0d done after release", i), {31'h0, done8}, 32'h0);
            check($sformatf("vec%0d p held after release", i), {16'h0, p8}, {16'h0, tbl[i].exp});
        end

        // Hold go for 1 us in DONE: no restart, result stable.
        run_op(1'b0, 1'b1, 16'd20, 16'h00F6, res, lat, bcnt, both);
        check("hold p", res, 32'h0000FF38);
        changed = 1'b0;
        ms8 = 1'b0; ain8 = 8'd3; pin8 = 8'd3;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            if (!done8 || busy8 || p8 !== 16'hFF38) changed = 1'b1;
        end
        check("hold stable no restart", {31'h0, changed}, 32'h0);
        release_go(1'b0);
        check("hold release done", {31'h0, done8}, 32'h0);

        // Abort: establish 0x03E8, then drop go on the 4th RUN edge.
        run_op(1'b0, 1'b1, 16'd25, 16'd40, res, lat, bcnt, both);
        release_go(1'b0);
        check("abort prior p", {16'h0, p8}, 32'h000003E8);
        @(negedge clk);
        ms8 = 1'b1; ain8 = 8'd20; pin8 = 8'hF6; go8 = 1'b1;
        @(posedge clk);
        saw_done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            if (done8) saw_done = 1'b1;
        end
        check("abort busy mid-run", {31'h0, busy8}, 32'h1);
        @(negedge clk);
        go8 = 1'b0;
        @(posedge clk);
        #1;
        check("abort busy", {31'h0, busy8}, 32'h0);
        check("abort done", {31'h0, done8}, 32'h0);
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (done8) saw_done = 1'b1;
        end
        check("abort done never high", {31'h0, saw_done}, 32'h0);
        check("abort p kept", {16'h0, p8}, 32'h000003E8);
        run_op(1'b0, 1'b1, 16'd20, 16'h00F6, res, lat, bcnt, both);
        check("restart p", res, 32'h0000FF38);
        check("restart latency", lat, 9);
        release_go(1'b0);

        // Asynchronous reset in the middle of RUN.
        @(negedge clk);
        ms8 = 1'b1; ain8 = 8'd25; pin8 = 8'd40; go8 = 1'b1;
        repeat (4) @(posedge clk);
        #3;
        check("pre-reset busy", {31'h0, busy8}, 32'h1);
        rst_n = 1'b0;
        #1;
        check("async reset busy", {31'h0, busy8}, 32'h0);
        check("async reset done", {31'h0, done8}, 32'h0);
        check("async reset p", {16'h0, p8}, 32'h0);
        go8 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        run_op(1'b0, 1'b1, 16'd25, 16'd40, res, lat, bcnt, both);
        check("post-reset p", res, 32'h000003E8);
        release_go(1'b0);

        // W=16 corners.
        run_op(1'b1, 1'b1, 16'h8000, 16'h8000, res, lat, bcnt, both);
        check("w16 -32768^2 p", res, 32'h40000000);
        check("w16 latency", lat, 17);
        check("w16 busy cycles", bcnt, 17);
        release_go(1'b1);
        run_op(1'b1, 1'b0, 16'hFFFF, 16'd2, res, lat, bcnt, both);
        check("w16 65535*2 p", res, 32'h0001FFFE);
        release_go(1'b1);

        // W=16 random pairs against a plain multiply.
        for (int i = 0; i < 1000; i++) begin
            logic [15:0] a, b;
            bit          sgn;
            a   = 16'($urandom);
            b   = 16'($urandom);
            sgn = 1'($urandom_range(0, 1));
            run_op(1'b1, sgn, a, b, res, lat, bcnt, both);
            check($sformatf("w16 rnd%0d s=%0d %h*%h", i, sgn, a, b), res, ref16(sgn, a, b));
            release_go(1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
